// File: rtl/useq_stack_sequencer.sv
// Microprogram sequencer: registered micro-address, LIFO return stack, loop counter.
// Define USEQ_STACK_WRAP_EN to make the return stack circular (overflowing pushes overwrite the oldest entry).
module useq_stack_sequencer #(
    parameter int AW    = 12,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [2:0]    op,
    input  logic          cond,
    input  logic [AW-1:0] d_in,
    input  logic          hold,
    output logic [AW-1:0] address,
    output logic [4:0]    depth,
    output logic          ctr_zero,
    output logic          overflow,
    output logic          underflow
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]    FULL = 5'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef enum logic [2:0] {
        OP_NEXT  = 3'd0,
        OP_JUMP  = 3'd1,
        OP_CALL  = 3'd2,
        OP_RET   = 3'd3,
        OP_LDCT  = 3'd4,
        OP_LOOP  = 3'd5,
        OP_JMAP  = 3'd6,
        OP_JUMPN = 3'd7
    } op_e;

    logic [AW-1:0] r_upc;
    logic [CW-1:0] r_ctr;
    logic [4:0]    r_depth;
    logic [PW-1:0] r_wp;
    logic          r_ovf;
    logic          r_unf;
    logic [AW-1:0] r_stack [DEPTH];

    logic [AW-1:0] w_inc;
    logic [AW-1:0] w_upc_nxt;
    logic [CW-1:0] w_ctr_nxt;
    logic [4:0]    w_depth_nxt;
    logic [PW-1:0] w_wp_nxt;
    logic [PW-1:0] w_wp_inc;
    logic [PW-1:0] w_wp_dec;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_wr_en;
    logic          w_ovf_set;
    logic          w_unf_set;

    assign w_inc    = r_upc + 1'b1;
    assign w_full   = (r_depth == FULL);
    assign w_empty  = (r_depth == 5'd0);
    // r_wp is the next write slot; the top of stack is always the slot just below it.
    assign w_wp_inc = (r_wp == LAST) ? '0 : r_wp + 1'b1;
    assign w_wp_dec = (r_wp == '0) ? LAST : r_wp - 1'b1;

    always_comb begin
        w_upc_nxt = w_inc;
        w_ctr_nxt = r_ctr;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_unf_set = 1'b0;
        unique case (op_e'(op))
            OP_NEXT:  w_upc_nxt = w_inc;
            OP_JUMP:  w_upc_nxt = cond ? d_in : w_inc;
            OP_CALL: begin
                if (cond) begin
                    w_push    = 1'b1;
                    w_upc_nxt = d_in;
                end
            end
            OP_RET: begin
                if (cond) begin
                    if (w_empty) begin
                        w_unf_set = 1'b1;
                    end else begin
                        w_pop     = 1'b1;
                        w_upc_nxt = r_stack[w_wp_dec];
                    end
                end
            end
            OP_LDCT:  w_ctr_nxt = d_in[CW-1:0];
            OP_LOOP: begin
                if (r_ctr != '0) begin
                    w_ctr_nxt = r_ctr - 1'b1;
                    w_upc_nxt = d_in;
                end
            end
            OP_JMAP:  w_upc_nxt = d_in;
            OP_JUMPN: w_upc_nxt = cond ? w_inc : d_in;
            default:  w_upc_nxt = w_inc;
        endcase
    end

    always_comb begin
        w_ovf_set   = w_push && w_full;
        w_wr_en     = 1'b0;
        w_wp_nxt    = r_wp;
        w_depth_nxt = r_depth;
        if (w_push) begin
`ifdef USEQ_STACK_WRAP_EN
            // When full, the write slot holds the oldest entry, so it is overwritten.
            w_wr_en  = 1'b1;
            w_wp_nxt = w_wp_inc;
            if (!w_full) begin
                w_depth_nxt = r_depth + 5'd1;
            end
`else
            if (!w_full) begin
                w_wr_en     = 1'b1;
                w_wp_nxt    = w_wp_inc;
                w_depth_nxt = r_depth + 5'd1;
            end
`endif
        end else if (w_pop) begin
            w_wp_nxt    = w_wp_dec;
            w_depth_nxt = r_depth - 5'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_upc   <= '0;
            r_ctr   <= '0;
            r_depth <= '0;
            r_wp    <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (!hold) begin
            r_upc   <= w_upc_nxt;
            r_ctr   <= w_ctr_nxt;
            r_depth <= w_depth_nxt;
            r_wp    <= w_wp_nxt;
            r_ovf   <= r_ovf | w_ovf_set;
            r_unf   <= r_unf | w_unf_set;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !hold && w_wr_en) begin
            r_stack[r_wp] <= w_inc;
        end
    end

    assign address   = r_upc;
    assign depth     = r_depth;
    assign ctr_zero  = (r_ctr == '0);
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: tb/tb_useq_stack_sequencer.sv
// Directed and randomized bench for useq_stack_sequencer against a queue-based reference model.
module tb_useq_stack_sequencer;

    localparam int AW    = 12;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int AMASK = (1 << AW) - 1;
    localparam int CMASK = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [2:0]    op    = 3'd0;
    logic          cond  = 1'b0;
    logic [AW-1:0] d_in  = '0;
    logic          hold  = 1'b0;
    logic [AW-1:0] address;
    logic [4:0]    depth;
    logic          ctr_zero;
    logic          overflow;
    logic          underflow;

    useq_stack_sequencer #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clock    (clock),
        .reset    (reset),
        .op       (op),
        .cond     (cond),
        .d_in     (d_in),
        .hold     (hold),
        .address  (address),
        .depth    (depth),
        .ctr_zero (ctr_zero),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_upc = 0;
    int m_ctr = 0;
    int m_stk[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int o, input bit c, input int d, input bit h, input bit r);
        int inc;
        if (r) begin
            m_upc = 0; m_ctr = 0; m_ovf = 0; m_unf = 0;
            m_stk.delete();
            return;
        end
        if (h) return;
        inc = (m_upc + 1) & AMASK;
        case (o)
            0: m_upc = inc;
            1: m_upc = c ? d : inc;
            2: begin
                if (c) begin
                    if (m_stk.size() == DEPTH) begin
                        m_ovf = 1;
`ifdef USEQ_STACK_WRAP_EN
                        void'(m_stk.pop_front());
                        m_stk.push_back(inc);
`endif
                    end else begin
                        m_stk.push_back(inc);
                    end
                    m_upc = d;
                end else m_upc = inc;
            end
            3: begin
                if (c && m_stk.size() == 0) begin
                    m_unf = 1;
                    m_upc = inc;
                end else if (c) m_upc = m_stk.pop_back();
                else m_upc = inc;
            end
            4: begin m_ctr = d & CMASK; m_upc = inc; end
            5: begin
                if (m_ctr != 0) begin m_ctr = m_ctr - 1; m_upc = d; end
                else m_upc = inc;
            end
            6: m_upc = d;
            default: m_upc = c ? inc : d;
        endcase
    endtask

    task automatic step(input int o, input bit c, input int d, input bit h, input bit r);
        op = 3'(o); cond = c; d_in = AW'(d); hold = h; reset = r;
        @(posedge clock);
        model(o, c, d, h, r);
        #1;
        chk("address",   32'(address),   32'(m_upc));
        chk("depth",     32'(depth),     32'(m_stk.size()));
        chk("ctr_zero",  32'(ctr_zero),  32'(m_ctr == 0));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    initial begin
        int prev;
        // 1: reset, NEXT x5, hold x2
        step(0, 0, 0, 0, 1);
        chk("rst_addr", 32'(address), 32'h0);
        chk("rst_flags", {30'd0, overflow, underflow}, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 0, 0, 0);
            chk("next_seq", 32'(address), 32'(i));
        end
        step(1, 1, 12'h333, 1, 0);
        step(2, 1, 12'h444, 1, 0);
        chk("hold_addr", 32'(address), 32'h5);
        // 2: call / return
        step(1, 1, 12'h010, 0, 0);
        step(2, 1, 12'h100, 0, 0);
        chk("call_addr", 32'(address), 32'h100);
        chk("call_depth", 32'(depth), 32'h1);
        step(3, 1, 0, 0, 0);
        chk("ret_addr", 32'(address), 32'h011);
        chk("ret_depth", 32'(depth), 32'h0);
        step(3, 0, 12'h555, 0, 0);
        chk("ret_nc_addr", 32'(address), 32'h012);
        // 3: counted loop
        step(1, 1, 12'h020, 0, 0);
        step(4, 0, 3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(5, 1, 12'h020, 0, 0);
            chk("loop_taken", 32'(address), 32'h020);
        end
        step(5, 0, 12'h020, 0, 0);
        chk("loop_exit", 32'(address), 32'h021);
        chk("loop_zero", 32'(ctr_zero), 32'h1);
        // 4: overflow and underflow
        for (int i = 0; i < 5; i++) step(2, 1, 12'h300 + i * 16, 0, 0);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_depth", 32'(depth), 32'h4);
        for (int i = 0; i < 4; i++) step(3, 1, 0, 0, 0);
        prev = int'(address);
        step(3, 1, 0, 0, 0);
        chk("unf_flag", 32'(underflow), 32'h1);
        chk("unf_addr", 32'(address), 32'((prev + 1) & AMASK));
        // 5: wrap, dispatch, inverted jump
        step(1, 1, 12'hFFF, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("wrap_addr", 32'(address), 32'h000);
        step(6, 0, 12'h07A, 0, 0);
        chk("jmap_c0", 32'(address), 32'h07A);
        step(6, 1, 12'h07A, 0, 0);
        chk("jmap_c1", 32'(address), 32'h07A);
        step(7, 0, 12'h200, 0, 0);
        chk("jumpn", 32'(address), 32'h200);
        // 6: reset mid-loop with hold asserted
        step(4, 0, 2, 0, 0);
        step(2, 1, 12'h400, 0, 0);
        step(2, 1, 12'h500, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("rst2_addr", 32'(address), 32'h0);
        chk("rst2_depth", 32'(depth), 32'h0);
        chk("rst2_zero", 32'(ctr_zero), 32'h1);
        chk("rst2_flags", {30'd0, overflow, underflow}, 32'h0);
        // Randomized traffic, with LDCT values kept small so loops terminate often
        for (int i = 0; i < 600; i++) begin
            int o;
            int d;
            o = int'($urandom_range(0, 7));
            d = int'($urandom_range(0, AMASK));
            if (o == 4) d = d & 7;
            step(o, 1'($urandom_range(0, 1)), d,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 79) == 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/useq_stack_sequencer.md
Name: useq_stack_sequencer

Overview:
- Parametrised microprogram sequencer producing the micro-address for the microcode ROM each cycle.
- Successor to the fixed 12-bit next/jump/call/return sequencer. Adds:
  - configurable address width and return-stack depth;
  - loop counter with load and decrement-branch ops;
  - dispatch op;
  - stall input;
  - stack overflow/underflow status.
- Sits between the microcode pipeline register (supplies op, cond, d_in) and the microcode ROM address input.

Parameters:
- AW, 12, micro-address width in bits.
- DEPTH, 4, return-stack entries (1..16).
- CW, 8, loop counter width; CW <= AW.

Ports:
- clock  input  1  single clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- op  input  3  sequencer operation code (see Behaviour).
- cond  input  1  selected branch condition from datapath.
- d_in  input  AW  branch target / dispatch address / counter load value.
- hold  input  1  stall. When 1, no state changes.
- address  output  AW  current micro-address (registered upc) driving ROM.
- depth  output  5  number of valid stack entries, 0..DEPTH.
- ctr_zero  output  1  1 when loop counter == 0.
- overflow  output  1  sticky; push attempted with depth == DEPTH.
- underflow  output  1  sticky; pop attempted with depth == 0.

Behaviour:
- Reset is synchronous: on a rising clock edge with reset = 1:
  - upc = 0, depth = 0, ctr = 0;
  - overflow = 0, underflow = 0;
  - stack contents don't-care.
  - reset overrides hold and op.
  - Reset mid-call/loop discards all stack and counter state.
- address = upc, registered. The new address is visible the cycle after the op is presented (1-cycle latency).
- inc = (upc + 1) mod 2^AW; wraps from all-ones to 0.
- hold = 1: upc, ctr, stack, depth and flags are all unchanged; op is ignored.
- Ops (hold = 0):
  - 0 NEXT: upc <= inc.
  - 1 JUMP: upc <= cond ? d_in : inc.
  - 2 CALL: if cond, push inc, upc <= d_in; else upc <= inc.
  - 3 RET: if cond, pop, upc <= top; else upc <= inc.
  - 4 LDCT: ctr <= d_in[CW-1:0]; upc <= inc. cond ignored.
  - 5 LOOP: if ctr != 0, ctr <= ctr - 1 and upc <= d_in; else upc <= inc. cond ignored.
  - 6 JMAP: upc <= d_in unconditionally (opcode dispatch).
  - 7 JUMPN: upc <= cond ? inc : d_in.
- Stack is LIFO; depth increments on push and decrements on pop. top = most recent entry.
- Push with depth == DEPTH (macro off):
  - entry discarded, depth unchanged;
  - overflow <= 1;
  - upc still <= d_in.
- Pop with depth == 0:
  - underflow <= 1, depth stays 0;
  - upc <= inc (fall through).
- overflow and underflow are sticky until reset.
- ctr never decrements below 0. LOOP with ctr == 0 falls through and leaves ctr at 0.
- Only one op per cycle, so counter and stack updates never conflict.

Optional Feature:
- Macro: USEQ_STACK_WRAP_EN.
- Defined: stack is circular. A push at depth == DEPTH overwrites the oldest entry, depth stays DEPTH, overflow still set to 1. Subsequent pops return the newest DEPTH addresses in LIFO order.
- Undefined: overflowing push is dropped as above.

Test Plan:
1. Reset, then 5 cycles of NEXT with hold = 0 -> address 0,1,2,3,4,5. Assert hold for 2 cycles -> address stays 5.
2. At upc = 0x010: CALL cond = 1, d_in = 0x100 -> address 0x100, depth 1. Then RET cond = 1 -> address 0x011, depth 0. RET cond = 0 at 0x011 -> 0x012.
3. LDCT d_in = 3 at upc = 0x020, then LOOP d_in = 0x020 repeatedly -> branches to 0x020 exactly 3 times, 4th LOOP goes to 0x021, ctr_zero = 1.
4. DEPTH = 4: five CALLs with cond = 1 -> overflow = 1, depth = 4. Five RETs -> fifth sets underflow = 1, address = previous + 1. With USEQ_STACK_WRAP_EN the four pops return return addresses of calls 5,4,3,2.
5. AW = 12, JUMP to 0xFFF then NEXT -> address 0x000. JMAP d_in = 0x07A -> 0x07A regardless of cond. JUMPN cond = 0 d_in = 0x200 -> 0x200.
6. Mid-loop (ctr = 2, depth = 2), assert reset for 1 cycle together with hold = 1 -> address 0, depth 0, ctr_zero 1, flags 0.
